// File: rtl/markov_cbo_puf_seq_if.sv
// Request/response and APUF-array bundle for markov_cbo_puf_seq.
// slave: the sequencer itself. master: whoever issues requests and models the APUF array.
interface markov_cbo_puf_seq_if #(
  parameter int N     = 16,
  parameter int K     = 8,
  parameter int STEPS = 4
);
  logic             start;
  logic [N-1:0]     c;
  logic             busy;
  logic             done;
  logic [STEPS-1:0] resp;
  logic             error;
  logic [N-1:0]     puf_c;
  logic             puf_tig;
  logic [K-1:0]     puf_ready;
  logic [K-1:0]     puf_resp;
  logic [K-1:0]     puf_resp_f;

  modport master (
    output start, c, puf_ready, puf_resp, puf_resp_f,
    input  busy, done, resp, error, puf_c, puf_tig
  );

  modport slave (
    input  start, c, puf_ready, puf_resp, puf_resp_f,
    output busy, done, resp, error, puf_c, puf_tig
  );
endinterface

// File: rtl/markov_cbo_puf_seq.sv
// Sequenced Markov challenge-feedback-obfuscation PUF controller.
// Runs STEPS chained APUF evaluations per request; each step's feedback bits
// obfuscate the next challenge and pick that step's response bit.
// Optional build macro MCBO_XOR_OUT_EN: step bit is the XOR of all K responses
// instead of the feedback-selected one.
module markov_cbo_puf_seq #(
  parameter int N       = 16,
  parameter int K       = 8,
  parameter int STEPS   = 4,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  markov_cbo_puf_seq_if.slave  bus
);

  localparam int LOG2K  = $clog2(K);
  localparam int STEP_W = $clog2(STEPS + 1);
  localparam int SET_W  = $clog2(SETTLE + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ARM, FIRE, CAPTURE, DONE} stateT;

  stateT             state;
  logic [N-1:0]      chalReg;
  logic [K-1:0]      fbReg;
  logic [STEP_W-1:0] stepCnt;
  logic [SET_W-1:0]  settleCnt;
  logic [TMO_W-1:0]  tmoCnt;
  logic [STEPS-1:0]  respReg;
  logic              errorReg;
  logic              busyReg;
  logic              doneReg;
  logic              tigReg;

  logic [STEP_W-1:0] stepNext;
  logic [TMO_W-1:0]  tmoNext;
  logic              stepBit;

  assign stepNext = stepCnt + STEP_W'(1);
  assign tmoNext  = tmoCnt + TMO_W'(1);

`ifdef MCBO_XOR_OUT_EN
  // Response bit folds every APUF output together.
  assign stepBit = ^bus.puf_resp;
`else
  // Bit b of the select index folds feedback bits whose position is b modulo log2(K).
  function automatic logic [K-1:0] selMask(input int b);
    selMask = '0;
    for (int j = 0; j < K; j++) begin
      selMask[j] = ((j % LOG2K) == b) ? 1'b1 : 1'b0;
    end
  endfunction

  logic [LOG2K-1:0] sel;

  for (genvar gi = 0; gi < LOG2K; gi++) begin : gSel
    localparam logic [K-1:0] MASK = selMask(gi);
    assign sel[gi] = ^(bus.puf_resp_f & MASK);
  end

  assign stepBit = bus.puf_resp[sel];
`endif

  // Obfuscated challenge: base challenge XOR feedback repeated across the width.
  for (genvar gi = 0; gi < N; gi++) begin : gPufC
    assign bus.puf_c[gi] = chalReg[gi] ^ fbReg[gi % K];
  end

  assign bus.busy    = busyReg;
  assign bus.done    = doneReg;
  assign bus.resp    = respReg;
  assign bus.error   = errorReg;
  assign bus.puf_tig = tigReg;

  // Request sequencer: settle, fire, capture per step, with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      chalReg   <= '0;
      fbReg     <= '0;
      stepCnt   <= '0;
      settleCnt <= '0;
      tmoCnt    <= '0;
      respReg   <= '0;
      errorReg  <= 1'b0;
      busyReg   <= 1'b0;
      doneReg   <= 1'b0;
      tigReg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            chalReg   <= bus.c;
            fbReg     <= '0;
            stepCnt   <= '0;
            respReg   <= '0;
            errorReg  <= 1'b0;
            settleCnt <= '0;
            busyReg   <= 1'b1;
            state     <= ARM;
          end
        end

        ARM: begin
          if (settleCnt == SET_W'(SETTLE - 1)) begin
            tmoCnt <= '0;
            tigReg <= 1'b1;
            state  <= FIRE;
          end else begin
            settleCnt <= settleCnt + SET_W'(1);
          end
        end

        FIRE: begin
          // Ready has priority over a timeout reached in the same cycle.
          if (&bus.puf_ready) begin
            state <= CAPTURE;
          end else begin
            if (tmoCnt != TMO_W'(TIMEOUT)) begin
              tmoCnt <= tmoNext;
            end
            if (tmoNext == TMO_W'(TIMEOUT)) begin
              errorReg <= 1'b1;
              tigReg   <= 1'b0;
              doneReg  <= 1'b1;
              state    <= DONE;
            end
          end
        end

        CAPTURE: begin
          for (int s = 0; s < STEPS; s++) begin
            if (stepCnt == STEP_W'(s)) begin
              respReg[s] <= stepBit;
            end
          end
          fbReg   <= bus.puf_resp_f;
          stepCnt <= stepNext;
          tigReg  <= 1'b0;
          if (stepNext == STEP_W'(STEPS)) begin
            doneReg <= 1'b1;
            state   <= DONE;
          end else begin
            settleCnt <= '0;
            state     <= ARM;
          end
        end

        DONE: begin
          doneReg <= 1'b0;
          busyReg <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_markov_cbo_puf_seq.sv
// Directed bench for markov_cbo_puf_seq (default parameters).
// Honours MCBO_XOR_OUT_EN when choosing expected response words.
module tb_markov_cbo_puf_seq;

  logic clk;
  logic rst_n;

  markov_cbo_puf_seq_if #(.N(16), .K(8), .STEPS(4)) bus ();

  markov_cbo_puf_seq dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] c;
    logic [7:0]  rf;
    logic [7:0]  r;
    logic [7:0]  rAlt;
    logic [3:0]  expMux;
    logic [3:0]  expXor;
    logic [15:0] pucLater;
  } vecT;

  vecT vecs[8];

  int nChecks = 0;
  int nFail   = 0;

  // Results of the last request
  int          resDoneCyc;
  logic [3:0]  resResp;
  logic        resErr;
  logic [15:0] resPucFirst;
  logic [15:0] resPucLater;
  int          resRun0;
  int          resRuns;
  bit          resBusyOk;
  bit          resPucStable;
  bit          resIdleOk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // One request; called at a negedge. Cycle 1 is the cycle after the accepting edge.
  task automatic runRequest(input logic [15:0] cVal, input logic [7:0] rfVal, input logic [7:0] rVal,
                            input logic [7:0] rAltVal, input logic [7:0] lowVal, input int lowCycles,
                            input bit pulseInArm);
    int cyc;
    int runIdx;
    int runLen;
    bit prevTig;
    bit finished;
    logic [15:0] tigPuc;
    bus.c          = cVal;
    bus.puf_resp_f = rfVal;
    bus.puf_resp   = rVal;
    bus.puf_ready  = 8'hFF;
    bus.start      = 1'b1;
    cyc = 0; runIdx = 0; runLen = 0; prevTig = 1'b0; finished = 1'b0; tigPuc = '0;
    resDoneCyc = -1; resBusyOk = 1'b1; resPucStable = 1'b1; resRun0 = 0;
    resPucFirst = '0; resPucLater = '0; resResp = '0; resErr = 1'b0;
    while (!finished && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      bus.start = pulseInArm && (cyc == 1);
      if (!bus.busy) resBusyOk = 1'b0;
      if (bus.puf_tig) begin
        if (!prevTig) begin
          if (runIdx == 0) resPucFirst = bus.puf_c;
          if (runIdx == 1) resPucLater = bus.puf_c;
          tigPuc = bus.puf_c;
        end else if (bus.puf_c !== tigPuc) begin
          resPucStable = 1'b0;
        end
        runLen++;
        if (runIdx == 0) bus.puf_ready = (runLen <= lowCycles) ? lowVal : 8'hFF;
      end else if (prevTig) begin
        if (runIdx == 0) resRun0 = runLen;
        runIdx++;
        runLen = 0;
        bus.puf_ready = 8'hFF;
      end
      prevTig = bus.puf_tig;
      bus.puf_resp = runIdx[0] ? rAltVal : rVal;
      if (bus.done) begin
        finished   = 1'b1;
        resDoneCyc = cyc;
        resResp    = bus.resp;
        resErr     = bus.error;
      end
    end
    bus.start = 1'b0;
    resRuns = runIdx;
    @(negedge clk);
    resIdleOk = !bus.busy && !bus.done && (bus.resp === resResp) && (bus.error === resErr);
  endtask

  initial begin
    logic [3:0] expResp;
    vecs[0] = '{16'h00F0, 8'h00, 8'h01, 8'h01, 4'hF, 4'hF, 16'h00F0};
    vecs[1] = '{16'h0000, 8'h01, 8'h02, 8'h02, 4'hF, 4'hF, 16'h0101};
    vecs[2] = '{16'h0000, 8'h01, 8'h01, 8'h01, 4'h0, 4'hF, 16'h0101};
    vecs[3] = '{16'h1234, 8'h00, 8'h03, 8'h03, 4'hF, 4'h0, 16'h1234};
    vecs[4] = '{16'h1000, 8'h04, 8'h10, 8'h10, 4'hF, 4'hF, 16'h1404};
    vecs[5] = '{16'hFFFF, 8'h81, 8'h08, 8'h08, 4'hF, 4'hF, 16'h7E7E};
    vecs[6] = '{16'hA5A5, 8'h00, 8'hFE, 8'hFE, 4'h0, 4'hF, 16'hA5A5};
    vecs[7] = '{16'h0000, 8'h00, 8'h01, 8'h00, 4'h5, 4'h5, 16'h0000};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.c = '0; bus.puf_ready = 8'hFF; bus.puf_resp = '0; bus.puf_resp_f = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'h0);
    check("reset done", 32'(bus.done), 32'h0);
    check("reset resp", 32'(bus.resp), 32'h0);
    check("reset error", 32'(bus.error), 32'h0);
    check("reset tig", 32'(bus.puf_tig), 32'h0);
    check("reset puf_c", 32'(bus.puf_c), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven requests with ready always high
    for (int i = 0; i < 8; i++) begin
`ifdef MCBO_XOR_OUT_EN
      expResp = vecs[i].expXor;
`else
      expResp = vecs[i].expMux;
`endif
      runRequest(vecs[i].c, vecs[i].rf, vecs[i].r, vecs[i].rAlt, 8'hFF, 0, 1'b0);
      $display("vec %0d: c=%h rf=%h r=%h done@%0d resp=%h err=%0d", i, vecs[i].c, vecs[i].rf,
               vecs[i].r, resDoneCyc, resResp, resErr);
      check($sformatf("v%0d done cycle", i), 32'(resDoneCyc), 32'd17);
      check($sformatf("v%0d resp", i), 32'(resResp), 32'(expResp));
      check($sformatf("v%0d error", i), 32'(resErr), 32'h0);
      check($sformatf("v%0d puf_c step0", i), 32'(resPucFirst), 32'(vecs[i].c));
      check($sformatf("v%0d puf_c step1", i), 32'(resPucLater), 32'(vecs[i].pucLater));
      check($sformatf("v%0d fire+capture len", i), 32'(resRun0), 32'd2);
      check($sformatf("v%0d trigger runs", i), 32'(resRuns), 32'd4);
      check($sformatf("v%0d busy window", i), 32'(resBusyOk), 32'h1);
      check($sformatf("v%0d puf_c stable", i), 32'(resPucStable), 32'h1);
      check($sformatf("v%0d idle after done", i), 32'(resIdleOk), 32'h1);
    end

    // Ready handshake: 10 FIRE cycles not ready, then ready
    runRequest(16'h00F0, 8'h00, 8'h01, 8'h01, 8'h7F, 10, 1'b0);
    $display("ready-wait: done@%0d resp=%h err=%0d run0=%0d", resDoneCyc, resResp, resErr, resRun0);
    check("ready-wait done cycle", 32'(resDoneCyc), 32'd27);
    check("ready-wait run0", 32'(resRun0), 32'd12);
    check("ready-wait error", 32'(resErr), 32'h0);
    check("ready-wait resp", 32'(resResp), 32'hF);
    check("ready-wait puf_c stable", 32'(resPucStable), 32'h1);

    // Timeout: never ready
    runRequest(16'h00F0, 8'h00, 8'h01, 8'h01, 8'h00, 100000, 1'b0);
    $display("timeout: done@%0d resp=%h err=%0d run0=%0d", resDoneCyc, resResp, resErr, resRun0);
    check("timeout done cycle", 32'(resDoneCyc), 32'd258);
    check("timeout error", 32'(resErr), 32'h1);
    check("timeout resp", 32'(resResp), 32'h0);
    check("timeout run0", 32'(resRun0), 32'd255);
    check("timeout sticky", 32'(resIdleOk), 32'h1);
    check("timeout error held", 32'(bus.error), 32'h1);

    // New start clears the error
    runRequest(16'h00F0, 8'h00, 8'h01, 8'h01, 8'hFF, 0, 1'b0);
    $display("after timeout: done@%0d resp=%h err=%0d", resDoneCyc, resResp, resErr);
    check("restart error cleared", 32'(resErr), 32'h0);
    check("restart resp", 32'(resResp), 32'hF);

    // Ready on the same FIRE cycle the timeout would hit: ready wins
    runRequest(16'h00F0, 8'h00, 8'h01, 8'h01, 8'h00, 254, 1'b0);
    $display("ready-at-limit: done@%0d resp=%h err=%0d run0=%0d", resDoneCyc, resResp, resErr, resRun0);
    check("limit done cycle", 32'(resDoneCyc), 32'd271);
    check("limit error", 32'(resErr), 32'h0);
    check("limit run0", 32'(resRun0), 32'd256);
    check("limit resp", 32'(resResp), 32'hF);

    // Start pulse during ARM is ignored
    runRequest(16'h00F0, 8'h00, 8'h01, 8'h01, 8'hFF, 0, 1'b1);
    $display("ignored start: done@%0d resp=%h", resDoneCyc, resResp);
    check("ignored start done cycle", 32'(resDoneCyc), 32'd17);
    check("ignored start resp", 32'(resResp), 32'hF);

    // Reset in the middle of step 2 FIRE
    bus.c = 16'h00F0; bus.puf_resp_f = 8'h01; bus.puf_resp = 8'h02; bus.puf_ready = 8'hFF;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    $display("mid-run: tig=%0d puf_c=%h busy=%0d", bus.puf_tig, bus.puf_c, bus.busy);
    check("mid-run tig", 32'(bus.puf_tig), 32'h1);
    check("mid-run puf_c", 32'(bus.puf_c), 32'h01F1);
    rst_n = 1'b0;
    @(negedge clk);
    $display("after reset: tig=%0d puf_c=%h busy=%0d resp=%h", bus.puf_tig, bus.puf_c, bus.busy, bus.resp);
    check("mid reset tig", 32'(bus.puf_tig), 32'h0);
    check("mid reset busy", 32'(bus.busy), 32'h0);
    check("mid reset resp", 32'(bus.resp), 32'h0);
    check("mid reset error", 32'(bus.error), 32'h0);
    check("mid reset done", 32'(bus.done), 32'h0);
    check("mid reset puf_c", 32'(bus.puf_c), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
